// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: datapath width, NOP encoding, fetch FSM states
// and the IF/ID slot layout that the ID stage also consumes.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        RSP  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched IF/ID slot; clear wins over load.
module if_skid_buf
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   clear,
    input  if_id_t d,
    output logic   valid,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else if (clear) begin
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

    assign valid = q.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one outstanding imem request, next-PC select, IF/ID register
// with stall/flush and a skid entry. Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_bubble_cnt_o,
`endif
    output logic [1:0]      dbg_state
);

    // Handshake: a request transfers on a cycle where imem_req_o & imem_ready_i;
    // imem_req_o never depends on imem_ready_i. A response is a single-cycle
    // imem_rvalid_i pulse with no back-pressure, honoured only in RSP/DROP.
    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] req_pc;
    if_id_t          if_id_q, if_id_d, skid_q, skid_d;
    logic            skid_valid, skid_load, skid_clear;
    logic            accept, deliver, hold;

    assign imem_req_o  = (state == REQ) & ~skid_valid & ~redirect_i;
    assign imem_addr_o = pc_i;
    assign accept      = imem_req_o & imem_ready_i;
    assign deliver     = (state == RSP) & imem_rvalid_i & ~redirect_i;
    assign hold        = stall_i & if_id_q.valid;
    assign dbg_state   = state;

    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i) begin
            pc_next_o = redirect_pc_i;
        end else if (accept) begin
            pc_next_o = pc_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ:     if (accept) state_nxt = RSP;
            RSP: begin
                if (imem_rvalid_i) begin
                    state_nxt = REQ;
                end else if (redirect_i) begin
                    state_nxt = DROP;
                end
            end
            DROP:    if (imem_rvalid_i) state_nxt = REQ;
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc <= '0;
        end else if (accept) begin
            req_pc <= pc_i;
        end
    end

    assign skid_d = '{valid: 1'b1, pc: req_pc, instr: imem_rdata_i};

    // Flush beats stall; a held slot parks the arriving response in the skid.
    always_comb begin
        if_id_d    = if_id_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect_i) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            skid_clear    = 1'b1;
        end else if (hold) begin
            skid_load = deliver;
        end else if (skid_valid) begin
            if_id_d    = skid_q;
            skid_clear = 1'b1;
        end else if (deliver) begin
            if_id_d = skid_d;
        end else begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (skid_d),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign if_id_valid_o = if_id_q.valid;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_instr_o = if_id_q.instr;

`ifdef IF_PERF_CNT_EN
    logic        loaded_valid;
    logic [31:0] fetch_cnt, bubble_cnt;

    assign loaded_valid = ~redirect_i & ~hold & if_id_d.valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (loaded_valid) fetch_cnt <= sat_inc(fetch_cnt);
            if (~stall_i & ~loaded_valid) bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

    assign perf_fetch_cnt_o  = fetch_cnt;
    assign perf_bubble_cnt_o = bubble_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic, all checked
// against a queue-based model of the fetch contract.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, pc_next_o, imem_addr_o, imem_rdata_i, redirect_pc_i;
    logic        imem_req_o, imem_ready_i, imem_rvalid_i, stall_i, redirect_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o, if_id_instr_o;
    logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o, perf_bubble_cnt_o;
`endif

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_next_o     (pc_next_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt_o  (perf_fetch_cnt_o),
        .perf_bubble_cnt_o (perf_bubble_cnt_o),
`endif
        .dbg_state     (dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // memory environment
    bit          mem_busy = 1'b0;
    int          mem_due  = 0;
    logic [31:0] mem_data = '0;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    bit          fi_en    = 1'b0;
    logic [31:0] fi_val   = '0;

    // reference model: outstanding request, whether its data is still wanted,
    // a skid queue and the IF/ID slot
    bit          m_out, m_want;
    logic [31:0] m_out_pc;
    logic [63:0] skq[$];
    bit          m_v;
    logic [31:0] m_pc, m_instr, m_fetch, m_bubble;

    logic        s_req;
    logic [31:0] s_next, s_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset;
        m_out    = 1'b0;
        m_want   = 1'b0;
        m_out_pc = '0;
        skq.delete();
        m_v      = 1'b0;
        m_pc     = '0;
        m_instr  = NOP;
        m_fetch  = '0;
        m_bubble = '0;
    endtask

    task automatic check_if_id;
        check("if_id_valid", 32'(if_id_valid_o), 32'(m_v));
        check("if_id_instr", if_id_instr_o, m_instr);
        if (m_v) check("if_id_pc", if_id_pc_o, m_pc);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt_o, m_fetch);
        check("perf_bubble", perf_bubble_cnt_o, m_bubble);
`endif
    endtask

    task automatic step(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc);
        bit          rv, exp_req, acc, dlv, load_v;
        logic [31:0] exp_next, nxt;
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        rv            = mem_busy && (cyc >= mem_due);
        imem_ready_i  = rdy;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_data : $urandom();
        stall_i       = stl;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        #1;
        exp_req  = !m_out && (skq.size() == 0) && !rdr;
        acc      = exp_req && rdy;
        exp_next = rdr ? rpc : (acc ? pc_i + 32'd4 : pc_i);
        check("imem_req", 32'(imem_req_o), 32'(exp_req));
        check("pc_next", pc_next_o, exp_next);
        check("imem_addr", imem_addr_o, pc_i);
        s_req  = imem_req_o;
        s_next = pc_next_o;
        s_addr = imem_addr_o;
        nxt    = pc_next_o;
        if (rv) mem_busy = 1'b0;
        if (imem_req_o && rdy) begin
            mem_busy = 1'b1;
            mem_due  = cyc + $urandom_range(lat_hi, lat_lo);
            mem_data = fi_en ? fi_val : $urandom();
        end
        dlv = m_out && rv && m_want && !rdr;
        if (m_out && rv) m_out = 1'b0;
        else if (m_out && rdr) m_want = 1'b0;
        load_v = 1'b0;
        if (rdr) begin
            m_v     = 1'b0;
            m_instr = NOP;
            skq.delete();
        end else if (stl && m_v) begin
            if (dlv) skq.push_back({m_out_pc, imem_rdata_i});
        end else if (skq.size() != 0) begin
            e       = skq.pop_front();
            m_v     = 1'b1;
            m_pc    = e[63:32];
            m_instr = e[31:0];
            load_v  = 1'b1;
        end else if (dlv) begin
            m_v     = 1'b1;
            m_pc    = m_out_pc;
            m_instr = imem_rdata_i;
            load_v  = 1'b1;
        end else begin
            m_v     = 1'b0;
            m_instr = NOP;
        end
        if (acc) begin
            m_out    = 1'b1;
            m_want   = 1'b1;
            m_out_pc = pc_i;
        end
        if (load_v && m_fetch != 32'hFFFF_FFFF) m_fetch++;
        if (!stl && !load_v && m_bubble != 32'hFFFF_FFFF) m_bubble++;
        @(posedge clk);
        #1;
        pc_i = nxt;
        check_if_id();
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        pc_i = '0;
        imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(if_id_valid_o), 32'd0);
        check("rst_instr", if_id_instr_o, 32'h00000013);
        check("rst_pc", if_id_pc_o, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd1);
        rst = 1'b0;

        // back-to-back fetch, 1-cycle memory
        fi_en = 1'b1; fi_val = 32'h00A00093;
        step(1, 0, 0, 0); check("d1_next0", s_next, 32'd4);
        step(1, 0, 0, 0); check("d1_next1", s_next, 32'd4);
        check("d1_valid", 32'(if_id_valid_o), 32'd1);
        check("d1_pc", if_id_pc_o, 32'd0);
        check("d1_instr", if_id_instr_o, 32'h00A00093);
        step(1, 0, 0, 0); check("d1_next2", s_next, 32'd8);
        step(1, 0, 0, 0); check("d1_pc2", if_id_pc_o, 32'd4);
        fi_en = 1'b0;

        // memory not ready for three cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("d2_req_held", 32'(s_req), 32'd1);
            check("d2_next_hold", s_next, 32'd8);
        end
        step(1, 0, 0, 0); check("d2_accept", s_next, 32'd12);
        step(1, 0, 0, 0); check("d2_pc", if_id_pc_o, 32'h8);

        // stall with a response landing in the skid
        step(1, 1, 0, 0); check("d3_hold0", if_id_pc_o, 32'h8);
        step(1, 1, 0, 0); check("d3_hold1", if_id_pc_o, 32'h8);
        step(1, 1, 0, 0); check("d3_noreq", 32'(s_req), 32'd0);
        check("d3_hold2", if_id_pc_o, 32'h8);
        step(1, 0, 0, 0); check("d3_skid_pc", if_id_pc_o, 32'hC);
        check("d3_skid_valid", 32'(if_id_valid_o), 32'd1);
        lat_lo = 3; lat_hi = 3;
        step(1, 0, 0, 0); check("d3_next_req", s_addr, 32'h10);
        check("d3_req", 32'(s_req), 32'd1);

        // redirect while waiting, late response dropped
        lat_lo = 1; lat_hi = 1;
        step(0, 0, 1, 32'h100); check("d4_next", s_next, 32'h100);
        check("d4_flush", if_id_instr_o, 32'h00000013);
        step(1, 0, 0, 0); check("d4_drop_noreq", 32'(s_req), 32'd0);
        step(1, 0, 0, 0); check("d4_discard", 32'(if_id_valid_o), 32'd0);
        step(1, 0, 0, 0); check("d4_addr", s_addr, 32'h100);

        // redirect and stall together with the skid full
        step(1, 1, 0, 0); check("d5_pc", if_id_pc_o, 32'h100);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 1, 32'h200); check("d5_next", s_next, 32'h200);
        check("d5_flush", 32'(if_id_valid_o), 32'd0);
        step(0, 0, 0, 0); check("d5_req", 32'(s_req), 32'd1);
        check("d5_addr", s_addr, 32'h200);
        check("d5_skid_gone", 32'(if_id_valid_o), 32'd0);

        // PC wrap, then reset with a response in flight
        step(0, 0, 1, 32'hFFFF_FFFC);
        lat_lo = 3; lat_hi = 3;
        step(1, 0, 0, 0); check("d6_wrap", s_next, 32'd0);
        step(0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check("d6_rst_valid", 32'(if_id_valid_o), 32'd0);
        check("d6_rst_instr", if_id_instr_o, 32'h00000013);
        check("d6_rst_state", 32'(dbg_state), 32'd0);
        pc_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); check("d6_late_ignored", 32'(if_id_valid_o), 32'd0);
        check("d6_req", 32'(s_req), 32'd1);

        // random traffic
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 3,
                 $urandom_range(9, 0) == 0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch control between the program counter register and the IF/ID boundary of the 5-stage RV32I pipeline.
- Issues one instruction-memory request per PC over a valid/ready handshake and tolerates variable response latency.
- Computes the next PC fed back to the program counter register, and owns the IF/ID pipeline register.
- Applies ID stall, EX branch/jump redirect (flush) and a one-entry skid buffer, so no fetched instruction is lost or duplicated.

Parameters:
- XLEN, 32, address/data width.
- NOP_INSTR, 32'h00000013, encoding driven on if_id_instr_o when the slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_i  in  XLEN  current PC from the program counter register
- pc_next_o  out  XLEN  next-PC value to the program counter register (loaded every clk)
- imem_req_o  out  1  request valid
- imem_addr_o  out  XLEN  request address (= pc_i)
- imem_ready_i  in  1  memory accepts the request this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  XLEN  fetched instruction
- stall_i  in  1  ID cannot accept; hold IF/ID
- redirect_i  in  1  taken branch/jump from EX; flush
- redirect_pc_i  in  XLEN  redirect target
- if_id_valid_o  out  1  IF/ID slot holds a real instruction
- if_id_pc_o  out  XLEN  PC of that instruction
- if_id_instr_o  out  XLEN  instruction, or NOP_INSTR when invalid

Behaviour:
- Reset (async, rst=1):
  - state=REQ; skid_valid=0; if_id_valid_o=0; if_id_pc_o=0; if_id_instr_o=NOP_INSTR.
  - The PC register resets itself to 0 independently.
- Definitions:
  - accept = imem_req_o & imem_ready_i.
  - imem_req_o = (state==REQ) & ~skid_valid & ~redirect_i.
  - imem_addr_o = pc_i.
- pc_next_o (combinational), in priority order:
  - redirect_i gives redirect_pc_i.
  - Otherwise, accept gives pc_i+4 (modulo 2^XLEN; wraps 0xFFFFFFFC to 0).
  - Otherwise, pc_i (hold).
- Only one request is outstanding at a time. The request address is captured as req_pc on accept.
- FSM:
  - REQ: on accept, go to RSP. If redirect_i, stay in REQ with no request.
  - RSP: on imem_rvalid_i & ~redirect_i, deliver {req_pc, imem_rdata_i} and go to REQ. On imem_rvalid_i & redirect_i, discard and go to REQ. On ~imem_rvalid_i & redirect_i, go to DROP.
  - DROP: on imem_rvalid_i, discard and go to REQ. redirect_i in DROP does not change state.
- IF/ID update, evaluated each clk:
  - redirect_i: valid=0, instr=NOP_INSTR, skid_valid=0. Flush beats stall.
  - Else if stall_i & if_id_valid_o: hold IF/ID. A delivered response is written to the skid (skid_valid=1).
  - Else, load IF/ID from the skid if skid_valid (skid clears, and a same-cycle delivery cannot occur). Otherwise load from the delivered response with valid=1. Otherwise valid=0 and instr=NOP_INSTR.
- Latency: with imem_ready_i=1 and 1-cycle rvalid, one instruction enters IF/ID every 2 cycles. A request accepted at cycle N yields IF/ID valid at N+2.
- While skid_valid=1, no request is issued, so the skid can never overflow.
- Reset mid-operation: any in-flight response arriving after reset deassertion in state REQ is ignored (rvalid only honoured in RSP/DROP).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt_o[31:0], which counts cycles with IF/ID valid load (instructions delivered).
  - Adds output perf_bubble_cnt_o[31:0], which counts cycles where ID is not stalled but IF/ID loads invalid.
  - Both reset to 0, saturate at 0xFFFFFFFF, and are not affected by redirect.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and NOP_INSTR.
  - Enum fetch_state_t {REQ, RSP, DROP}.
  - Struct if_id_t {valid, pc, instr}, which the ID stage reuses.
- One sub-module, if_skid_buf: a one-entry holding register of if_id_t with load/clear/valid.

Test Plan:
- Reset, then imem_ready_i=1 and rvalid 1 cycle after accept, instr=32'h00A00093 -> IF/ID valid at cycle 2 with pc=0; second fetch has pc=4; pc_next_o sequence 4, 4, 8.
- imem_ready_i=0 for 3 cycles -> imem_req_o held, pc_next_o=pc_i, no IF/ID load; accept on the 4th cycle.
- stall_i=1 with IF/ID valid (pc=0x8) and response for 0xC arriving -> IF/ID holds 0x8 and the skid captures 0xC; no new request; stall_i drops -> IF/ID=0xC next cycle; request for 0x10 follows.
- redirect_i=1 with redirect_pc_i=0x100 in RSP, rvalid arriving 2 cycles later -> DROP, response discarded, IF/ID invalid/NOP, next request address 0x100.
- redirect_i and stall_i together with the skid full -> IF/ID and skid cleared, pc_next_o=redirect_pc_i.
- pc_i=0xFFFFFFFC accepted -> pc_next_o=0; async rst asserted in RSP -> outputs at reset values immediately, and a late rvalid is ignored.
